// File: rtl/hier_leaf_stream_stage.sv
// ============================================================================
// hier_leaf_stream_stage
//   Leaf stream stage: valid/ready FIFO with running XOR checksum and drain.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hier_leaf_stream_stage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              flush_done,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                flush_done_q, flush_done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                push;
  logic                pop;

  assign in_ready   = (count_q != CNT_W'(DEPTH)) && (state_q == ST_STREAM);
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign checksum   = checksum_q;
  assign flush_done = flush_done_q;

  always_comb begin
    push         = in_valid & in_ready;
    pop          = out_valid & out_ready;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    checksum_d   = push ? (checksum_q ^ in_data) : checksum_q;
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // The cycle carrying flush_done ignores flush, so a held level
        // produces a flush_done that toggles every cycle.
        if (flush && !flush_done_q) begin
          if (count_d == '0) begin
            flush_done_d = 1'b1;
            checksum_d   = '0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d      = ST_STREAM;
          flush_done_d = 1'b1;
          checksum_d   = '0;
        end
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_STREAM;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      checksum_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      checksum_q   <= checksum_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hier_leaf_stream_stage.sv
// ============================================================================
// tb_hier_leaf_stream_stage
//   Directed vector table plus randomized run against a queue-based model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hier_leaf_stream_stage;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              flush_done;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] checksum;

  hier_leaf_stream_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .flush_done (flush_done),
    .count      (count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              flush;
    logic              e_ir;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic [CNT_W-1:0]  e_cnt;
    logic [DATA_W-1:0] e_cs;
    logic              e_fd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_cs    = '0;
  logic              m_drain = 1'b0;
  logic              m_fd    = 1'b0;

  function automatic void add(input logic r, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic fl, input logic eir,
                              input logic eov, input logic [7:0] eod,
                              input logic [2:0] ecnt, input logic [7:0] ecs,
                              input logic efd);
    vec_t v;
    v.rst_n = r;  v.in_valid = iv; v.in_data = id; v.out_ready = ordy; v.flush = fl;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_cnt = ecnt; v.e_cs = ecs; v.e_fd = efd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_step(input logic r, input logic iv, input logic [7:0] id,
                            input logic ordy, input logic fl);
    logic exp_ir, do_push, do_pop, nfd;
    if (!r) begin
      mq.delete();
      m_cs = '0; m_drain = 1'b0; m_fd = 1'b0;
    end else begin
      exp_ir  = !m_drain && (mq.size() < DEPTH);
      do_push = iv && exp_ir;
      do_pop  = (mq.size() > 0) && ordy;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(id);
        m_cs = m_cs ^ id;
      end
      nfd = 1'b0;
      if (!m_drain) begin
        if (fl && !m_fd) begin
          if (mq.size() == 0) begin
            nfd = 1'b1; m_cs = '0;
          end else begin
            m_drain = 1'b1;
          end
        end
      end else if (mq.size() == 0) begin
        m_drain = 1'b0; nfd = 1'b1; m_cs = '0;
      end
      m_fd = nfd;
    end
  endtask

  initial begin
    logic [7:0] cs_run;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // reset then idle
    add(0,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    add(0,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    add(1,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    // fill to full, fifth word held
    add(1,1,8'h11,0,0, 1,1,8'h11,1,8'h11,0);
    add(1,1,8'h22,0,0, 1,1,8'h11,2,8'h33,0);
    add(1,1,8'h33,0,0, 1,1,8'h11,3,8'h00,0);
    add(1,1,8'h44,0,0, 0,1,8'h11,4,8'h44,0);
    add(1,1,8'h55,0,0, 0,1,8'h11,4,8'h44,0);
    // pop at full, then simultaneous push/pop, then drain
    add(1,1,8'h55,1,0, 1,1,8'h22,3,8'h44,0);
    add(1,1,8'h55,1,0, 1,1,8'h33,3,8'h11,0);
    add(1,0,8'h00,1,0, 1,1,8'h44,2,8'h11,0);
    add(1,0,8'h00,1,0, 1,1,8'h55,1,8'h11,0);
    add(1,0,8'h00,1,0, 1,0,8'h00,0,8'h11,0);
    // zero-length flush held: flush_done toggles
    add(1,0,8'h00,0,1, 1,0,8'h00,0,8'h00,1);
    add(1,0,8'h00,0,1, 1,0,8'h00,0,8'h00,0);
    add(1,0,8'h00,0,1, 1,0,8'h00,0,8'h00,1);
    add(1,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    // wrap-around streaming
    cs_run = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      cs_run = cs_run ^ 8'(i);
      add(1,1,8'(i),1,0, 1,1,8'(i),1,cs_run,0);
    end
    add(1,0,8'h00,1,0, 1,0,8'h00,0,8'h0B,0);
    // flush with data; pushes during drain are refused
    add(1,1,8'hA0,0,0, 1,1,8'hA0,1,8'hAB,0);
    add(1,1,8'h0B,0,0, 1,1,8'hA0,2,8'hA0,0);
    add(1,1,8'hC0,0,0, 1,1,8'hA0,3,8'h60,0);
    add(1,0,8'h00,0,1, 0,1,8'hA0,3,8'h60,0);
    add(1,1,8'h77,1,0, 0,1,8'h0B,2,8'h60,0);
    add(1,1,8'h77,1,0, 0,1,8'hC0,1,8'h60,0);
    add(1,1,8'h77,1,0, 1,0,8'h00,0,8'h00,1);
    add(1,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    // reset during drain
    add(1,1,8'h12,0,0, 1,1,8'h12,1,8'h12,0);
    add(1,1,8'h34,0,0, 1,1,8'h12,2,8'h26,0);
    add(1,0,8'h00,0,1, 0,1,8'h12,2,8'h26,0);
    add(0,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);
    add(1,0,8'h00,0,0, 1,0,8'h00,0,8'h00,0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n = vecs[k].rst_n; in_valid = vecs[k].in_valid; in_data = vecs[k].in_data;
      out_ready = vecs[k].out_ready; flush = vecs[k].flush;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d in_ready", k),   {31'd0, in_ready},   {31'd0, vecs[k].e_ir});
      chk($sformatf("vec%0d out_valid", k),  {31'd0, out_valid},  {31'd0, vecs[k].e_ov});
      chk($sformatf("vec%0d count", k),      32'(count),          32'(vecs[k].e_cnt));
      chk($sformatf("vec%0d checksum", k),   32'(checksum),       32'(vecs[k].e_cs));
      chk($sformatf("vec%0d flush_done", k), {31'd0, flush_done}, {31'd0, vecs[k].e_fd});
      if (vecs[k].e_ov)
        chk($sformatf("vec%0d out_data", k), 32'(out_data),       32'(vecs[k].e_od));
    end

    // randomized run; DUT is idle in STREAM, matching the initial model state
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      chk("rnd in_ready",   {31'd0, in_ready},   {31'd0, (!m_drain && mq.size() < DEPTH)});
      chk("rnd out_valid",  {31'd0, out_valid},  {31'd0, (mq.size() > 0)});
      chk("rnd count",      32'(count),          32'(mq.size()));
      chk("rnd checksum",   32'(checksum),       32'(m_cs));
      chk("rnd flush_done", {31'd0, flush_done}, {31'd0, m_fd});
      if (mq.size() > 0) chk("rnd out_data", 32'(out_data), 32'(mq[0]));
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 14) == 0);
      model_step(rst_n, in_valid, in_data, out_ready, flush);
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
